// File: rtl/msx_mouse_pkg.sv
// Shared types and constants for the MSX mouse port: phase encoding, idle nibble, clamp limits.
package msx_mouse_pkg;

   typedef enum logic [1:0] {
      PH_XH = 2'd0,
      PH_XL = 2'd1,
      PH_YH = 2'd2,
      PH_YL = 2'd3
   } phase_t;

   localparam logic [3:0] NIB_IDLE  = 4'hF;
   localparam int         CLAMP_MAX = 32'sd127;
   localparam int         CLAMP_MIN = -32'sd128;

endpackage

// File: rtl/msx_mouse_port_if.sv
// Decoder-side and joystick-side signals of the MSX mouse port, grouped as one bus.
interface msx_mouse_port_if;

   logic       port_en;
   logic       move_stb;
   logic [7:0] dx;
   logic [7:0] dy;
   logic       btn_l_n;
   logic       btn_r_n;
   logic       strobe;
   logic [3:0] joy_data;
   logic       trg_a_n;
   logic       trg_b_n;

   modport master (
      output port_en, move_stb, dx, dy, btn_l_n, btn_r_n, strobe,
      input  joy_data, trg_a_n, trg_b_n
   );

   modport slave (
      input  port_en, move_stb, dx, dy, btn_l_n, btn_r_n, strobe,
      output joy_data, trg_a_n, trg_b_n
   );

endinterface

// File: rtl/msx_mouse_acc.sv
// Per-axis saturating motion accumulator with clear, latch-and-subtract and delta add.
// Optional delta acceleration is enabled by defining MSX_MOUSE_ACCEL_EN.
module msx_mouse_acc
   import msx_mouse_pkg::*;
#(
   parameter int ACC_W = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       add,
   input  logic [7:0] delta,
   input  logic       latch,
   output logic [7:0] clamp_val,
   output logic [7:0] lat_val
);

   localparam int SUM_W   = ACC_W + 2;
   localparam int ACC_LIM = (32'sd1 <<< (ACC_W - 1)) - 32'sd1;
   localparam logic signed [SUM_W-1:0] SUM_HI = SUM_W'(ACC_LIM);
   localparam logic signed [SUM_W-1:0] SUM_LO = SUM_W'(-ACC_LIM);
   localparam logic signed [ACC_W-1:0] CLP_HI = ACC_W'(CLAMP_MAX);
   localparam logic signed [ACC_W-1:0] CLP_LO = ACC_W'(CLAMP_MIN);

   function automatic logic signed [9:0] shape_delta(input logic [7:0] d);
      logic signed [9:0] w;
      w = {{2{d[7]}}, d};
`ifdef MSX_MOUSE_ACCEL_EN
      // Larger moves are doubled minus a fixed knee so small moves keep precision.
      if (w > 10'sd8) begin
         w = (w <<< 1) - 10'sd8;
      end else if (w < -10'sd8) begin
         w = (w <<< 1) + 10'sd8;
      end else begin
         w = w;
      end
`endif
      return w;
   endfunction

   logic signed [ACC_W-1:0] acc_r;
   logic signed [ACC_W-1:0] acc_nxt_s;
   logic        [7:0]       clamp_s;
   logic        [7:0]       lat_r;
   logic signed [SUM_W-1:0] base_s;
   logic signed [SUM_W-1:0] sum_s;
   logic signed [9:0]       delta_s;

   // Clamp the running total to the byte range the MSX protocol can carry.
   always_comb begin
      if (acc_r > CLP_HI) begin
         clamp_s = 8'h7F;
      end else if (acc_r < CLP_LO) begin
         clamp_s = 8'h80;
      end else begin
         clamp_s = acc_r[7:0];
      end
   end

   // Next total: latch removes the reported part, then the new delta lands on the residual.
   always_comb begin
      delta_s = shape_delta(delta);
      if (clr) begin
         base_s = {SUM_W{1'b0}};
      end else if (latch) begin
         base_s = {{2{acc_r[ACC_W-1]}}, acc_r} - {{(SUM_W-8){clamp_s[7]}}, clamp_s};
      end else begin
         base_s = {{2{acc_r[ACC_W-1]}}, acc_r};
      end
      if (add) begin
         sum_s = base_s + {{(SUM_W-10){delta_s[9]}}, delta_s};
      end else begin
         sum_s = base_s;
      end
      if (sum_s > SUM_HI) begin
         acc_nxt_s = ACC_W'(ACC_LIM);
      end else if (sum_s < SUM_LO) begin
         acc_nxt_s = ACC_W'(-ACC_LIM);
      end else begin
         acc_nxt_s = sum_s[ACC_W-1:0];
      end
   end

   // Accumulator and latched-byte registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_r <= {ACC_W{1'b0}};
         lat_r <= 8'h00;
      end else begin
         acc_r <= acc_nxt_s;
         if (latch) begin
            lat_r <= clamp_s;
         end
      end
   end

   assign clamp_val = clamp_s;
   assign lat_val   = lat_r;

endmodule

// File: rtl/msx_mouse_port.sv
// MSX joystick-port mouse: accumulates PS/2 deltas and serves them as strobed nibbles.
// Build option MSX_MOUSE_ACCEL_EN enables delta acceleration inside msx_mouse_acc.
module msx_mouse_port
   import msx_mouse_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 32768,
   parameter int ACC_W          = 10
) (
   input logic              clk,
   input logic              reset,
   msx_mouse_port_if.slave  bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES - 32'sd1);

   logic              strb_s1_r;
   logic              strb_s2_r;
   logic              strb_s3_r;
   logic              strb_edge_r;
   logic              port_en_r;
   logic [CNT_W-1:0]  to_cnt_r;
   phase_t            phase_r;
   phase_t            phase_nxt_s;
   logic [3:0]        joy_r;
   logic [3:0]        joy_nxt_s;
   logic              trg_a_r;
   logic              trg_b_r;
   logic              latch_s;
   logic              clr_s;
   logic [7:0]        x_clamp_s;
   logic [7:0]        y_clamp_s;
   logic [7:0]        x_lat_s;
   logic [7:0]        y_lat_s;

   assign clr_s = bus.port_en & ~port_en_r;

   msx_mouse_acc #(.ACC_W(ACC_W)) u_acc_x (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr_s),
      .add       (bus.move_stb),
      .delta     (bus.dx),
      .latch     (latch_s),
      .clamp_val (x_clamp_s),
      .lat_val   (x_lat_s)
   );

   msx_mouse_acc #(.ACC_W(ACC_W)) u_acc_y (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr_s),
      .add       (bus.move_stb),
      .delta     (bus.dy),
      .latch     (latch_s),
      .clamp_val (y_clamp_s),
      .lat_val   (y_lat_s)
   );

   // Strobe synchroniser, edge flag and port_en history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         strb_s1_r   <= 1'b0;
         strb_s2_r   <= 1'b0;
         strb_s3_r   <= 1'b0;
         strb_edge_r <= 1'b0;
         port_en_r   <= 1'b0;
      end else begin
         strb_s1_r   <= bus.strobe;
         strb_s2_r   <= strb_s1_r;
         strb_s3_r   <= strb_s2_r;
         strb_edge_r <= strb_s2_r ^ strb_s3_r;
         port_en_r   <= bus.port_en;
      end
   end

   // Idle counter since the last strobe edge, saturating at the timeout value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt_r <= {CNT_W{1'b0}};
      end else if (strb_edge_r) begin
         to_cnt_r <= {CNT_W{1'b0}};
      end else if (to_cnt_r != TO_MAX) begin
         to_cnt_r <= to_cnt_r + CNT_W'(32'd1);
      end else begin
         to_cnt_r <= to_cnt_r;
      end
   end

   // Phase sequencing and nibble selection.
   always_comb begin
      phase_nxt_s = phase_r;
      joy_nxt_s   = joy_r;
      latch_s     = 1'b0;
      if (!bus.port_en) begin
         phase_nxt_s = PH_XH;
         joy_nxt_s   = NIB_IDLE;
      end else if (strb_edge_r) begin
         case (phase_r)
            PH_XH: begin
               latch_s     = 1'b1;
               joy_nxt_s   = x_clamp_s[7:4];
               phase_nxt_s = PH_XL;
            end
            PH_XL: begin
               joy_nxt_s   = x_lat_s[3:0];
               phase_nxt_s = PH_YH;
            end
            PH_YH: begin
               joy_nxt_s   = y_lat_s[7:4];
               phase_nxt_s = PH_YL;
            end
            PH_YL: begin
               joy_nxt_s   = y_lat_s[3:0];
               phase_nxt_s = PH_XH;
            end
            default: begin
               phase_nxt_s = PH_XH;
            end
         endcase
      end else if (to_cnt_r == TO_MAX) begin
         // Host abandoned the read; restart so the next edge latches fresh data.
         phase_nxt_s = PH_XH;
      end else begin
         phase_nxt_s = phase_r;
      end
   end

   // Phase, nibble and trigger output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_r <= PH_XH;
         joy_r   <= 4'h0;
         trg_a_r <= 1'b1;
         trg_b_r <= 1'b1;
      end else begin
         phase_r <= phase_nxt_s;
         joy_r   <= joy_nxt_s;
         trg_a_r <= bus.port_en ? bus.btn_l_n : 1'b1;
         trg_b_r <= bus.port_en ? bus.btn_r_n : 1'b1;
      end
   end

   assign bus.joy_data = joy_r;
   assign bus.trg_a_n  = trg_a_r;
   assign bus.trg_b_n  = trg_b_r;

endmodule

// File: tb/tb_msx_mouse_port.sv
// Self-checking bench for msx_mouse_port: directed protocol cases plus randomized traffic
// against a transaction-level model of the accumulate/latch/nibble rules.
module tb_msx_mouse_port;

   localparam int TO    = 256;
   localparam int ACC_W = 10;
   localparam int LIM   = (1 << (ACC_W - 1)) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   msx_mouse_port_if bus ();

   msx_mouse_port #(.TIMEOUT_CYCLES(TO), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // model state
   int m_ax, m_ay, m_lx, m_ly, m_ph, m_joy, m_idle;
   bit m_en;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int accel(input int d);
`ifdef MSX_MOUSE_ACCEL_EN
      if (d > 8) return 2 * d - 8;
      if (d < -8) return 2 * d + 8;
`endif
      return d;
   endfunction

   function automatic int sat(input int v);
      if (v > LIM) return LIM;
      if (v < -LIM) return -LIM;
      return v;
   endfunction

   function automatic int clamp8(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   task automatic model_reset();
      m_ax = 0; m_ay = 0; m_lx = 0; m_ly = 0; m_ph = 0; m_joy = 0; m_idle = 0;
   endtask

   // one strobe edge seen by the model; with latch-time delta for the same-cycle case
   task automatic model_edge(input bit with_move, input int mdx, input int mdy);
      if (!m_en) begin
         m_ph  = 0;
         m_joy = 15;
      end else begin
         case (m_ph)
            0: begin
               m_lx = clamp8(m_ax); m_ly = clamp8(m_ay);
               m_ax = m_ax - m_lx;  m_ay = m_ay - m_ly;
               m_joy = (m_lx >> 4) & 15;
            end
            1: m_joy = m_lx & 15;
            2: m_joy = (m_ly >> 4) & 15;
            default: m_joy = m_ly & 15;
         endcase
         m_ph = (m_ph + 1) % 4;
      end
      if (with_move) begin
         m_ax = sat(m_ax + accel(mdx));
         m_ay = sat(m_ay + accel(mdy));
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      m_idle += n;
   endtask

   task automatic do_move(input logic [7:0] dx, input logic [7:0] dy);
      bus.dx = dx; bus.dy = dy; bus.move_stb = 1'b1;
      tick(1);
      bus.move_stb = 1'b0;
      tick(1);
      m_ax = sat(m_ax + accel(int'($signed(dx))));
      m_ay = sat(m_ay + accel(int'($signed(dy))));
   endtask

   task automatic do_read(input string tag);
      bus.strobe = ~bus.strobe;
      tick(6);
      model_edge(1'b0, 0, 0);
      check_val(tag, 32'(bus.joy_data), 32'(m_joy));
      m_idle = 0;
   endtask

   task automatic read_frame(input string tag);
      for (int i = 0; i < 4; i++) do_read(tag);
   endtask

   task automatic do_timeout();
      tick(TO + 10);
      m_ph = 0;
      m_idle = 0;
      check_val("timeout_hold", 32'(bus.joy_data), 32'(m_joy));
   endtask

   // move_stb lands exactly on the cycle the PH_XH edge latches
   task automatic do_same(input logic [7:0] dx, input logic [7:0] dy);
      int old;
      while (m_ph != 0) do_read("align");
      old = m_joy;
      bus.strobe = ~bus.strobe;
      tick(3);
      check_val("lat_early", 32'(bus.joy_data), 32'(old));
      bus.dx = dx; bus.dy = dy; bus.move_stb = 1'b1;
      tick(1);
      bus.move_stb = 1'b0;
      model_edge(1'b1, int'($signed(dx)), int'($signed(dy)));
      check_val("lat_edge", 32'(bus.joy_data), 32'(m_joy));
      tick(2);
      m_idle = 0;
   endtask

   task automatic do_btn(input logic [1:0] b);
      bus.btn_l_n = b[0]; bus.btn_r_n = b[1];
      tick(1);
      check_val("trg_a", 32'(bus.trg_a_n), m_en ? 32'(b[0]) : 32'd1);
      check_val("trg_b", 32'(bus.trg_b_n), m_en ? 32'(b[1]) : 32'd1);
   endtask

   task automatic do_port_cycle();
      bus.port_en = 1'b0;
      m_en = 1'b0; m_ph = 0; m_joy = 15;
      tick(2);
      check_val("dis_joy", 32'(bus.joy_data), 32'hF);
      check_val("dis_trg_a", 32'(bus.trg_a_n), 32'd1);
      check_val("dis_trg_b", 32'(bus.trg_b_n), 32'd1);
      do_move(8'h11, 8'hEE);
      do_read("dis_read");
      do_read("dis_read");
      bus.port_en = 1'b1;
      m_en = 1'b1;
      tick(3);
      m_ax = 0; m_ay = 0;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int r, tdx, tdy;
      reset = 1'b0;
      bus.port_en = 1'b1; bus.move_stb = 1'b0; bus.dx = 8'h00; bus.dy = 8'h00;
      bus.btn_l_n = 1'b1; bus.btn_r_n = 1'b1; bus.strobe = 1'b0;
      model_reset();
      m_en = 1'b1;
      tick(3);
      check_val("rst_joy", 32'(bus.joy_data), 32'h0);
      check_val("rst_trg_a", 32'(bus.trg_a_n), 32'd1);
      check_val("rst_trg_b", 32'(bus.trg_b_n), 32'd1);
      reset = 1'b1;
      tick(3);

      // basic frame then empty frame
      do_move(8'h25, 8'hF0);
      read_frame("frame1");
      read_frame("frame_empty");

      // saturating clamp with residual carried across reads
      do_move(8'd100, 8'd0); do_move(8'd100, 8'd0); do_move(8'd100, 8'd0);
      read_frame("clamp1");
      read_frame("clamp2");
      read_frame("clamp3");

      // timeout restart mid-frame
      do_move(8'd40, 8'hF9);
      do_read("to_pre");
      do_read("to_pre");
      do_timeout();
      do_move(8'd9, 8'd2);
      read_frame("to_post");

      // delta arriving on the latch cycle
      do_move(8'd5, 8'd0);
      do_same(8'd3, 8'd0);
      do_read("same_rest"); do_read("same_rest"); do_read("same_rest");
      read_frame("same_next");

      // acceleration on/off
      do_move(8'd20, 8'd0);
      do_read("acc_xh");
`ifdef MSX_MOUSE_ACCEL_EN
      check_val("accel_xh_const", 32'(bus.joy_data), 32'h2);
`else
      check_val("accel_xh_const", 32'(bus.joy_data), 32'h1);
`endif
      do_read("acc_xl");
`ifdef MSX_MOUSE_ACCEL_EN
      check_val("accel_xl_const", 32'(bus.joy_data), 32'h0);
`else
      check_val("accel_xl_const", 32'(bus.joy_data), 32'h4);
`endif
      do_read("acc_yh"); do_read("acc_yl");

      // buttons and port disable
      do_btn(2'b10);
      do_btn(2'b01);
      do_port_cycle();
      do_btn(2'b11);

      // asynchronous reset mid-frame
      do_move(8'h33, 8'h44);
      do_read("pre_rst"); do_read("pre_rst");
      reset = 1'b0;
      #1;
      check_val("async_rst_joy", 32'(bus.joy_data), 32'h0);
      bus.strobe = 1'b0;
      model_reset();
      tick(2);
      reset = 1'b1;
      tick(3);
      do_move(8'h12, 8'h34);
      read_frame("post_rst");

      // randomized traffic
      for (int it = 0; it < 300; it++) begin
         if (m_idle > TO / 2) do_timeout();
         r = $urandom_range(0, 19);
         if (r < 7) begin
            tdx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20)) - 10;
            tdy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20)) - 10;
            do_move(8'(tdx), 8'(tdy));
         end else if (r < 14) begin
            do_read("rnd_read");
         end else if (r < 16) begin
            do_btn(2'($urandom_range(0, 3)));
         end else if (r < 18) begin
            if (m_en) do_same(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            else do_read("rnd_read");
         end else if (r == 18) begin
            do_timeout();
         end else begin
            do_port_cycle();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
